i2s_stream_core: RTL and testbench

Stereo I2S serial core plus a chunk processor: deserialises 32-bit I2S words from the ADC, serialises 32-bit words to the DAC, and, on each chunk pulse, copies a 64-sample, 24-bit chunk from an input buffer RAM to an output buffer RAM through a gain stage. It sits between the ADC/DAC pins and the ping-pong sample RAMs in the audio top level. The I2S sections run on `bck`; the processor runs on system `clk`.

---
 rtl/i2s_stream_core.sv | 187 ++++++++++++++++++
 tb/tb_i2s_stream_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stream_core.sv
// Stereo I2S receiver/transmitter on bck plus a clk-domain chunk processor that
// copies one buffer of samples from the input RAM to the output RAM through a gain shift.
module i2s_stream_core #(
    parameter int WORD_SIZE   = 32,
    parameter int SAMPLE_SIZE = 24,
    parameter int PTR_BITS    = 6,
    parameter int GAIN_SHIFT  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bck,
    input  logic                   lrck,
    input  logic                   din,
    output logic [WORD_SIZE-1:0]   l_dout,
    output logic [WORD_SIZE-1:0]   r_dout,
    input  logic [WORD_SIZE-1:0]   l_din,
    input  logic [WORD_SIZE-1:0]   r_din,
    output logic                   dout,
    input  logic                   chunk_pulse,
    output logic [PTR_BITS-1:0]    input_buff_ptr,
    input  logic [SAMPLE_SIZE-1:0] input_buff_sample,
    output logic [PTR_BITS-1:0]    output_buff_ptr,
    output logic [SAMPLE_SIZE-1:0] output_buff_sample,
    output logic                   output_buff_write_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    logic [WORD_SIZE-1:0]          sh_rx_r;
    logic [WORD_SIZE-1:0]          rx_word_s;
    logic                          lrck_p_r;
    logic [WORD_SIZE-1:0]          sh_tx_r;
    logic [WORD_SIZE-1:0]          tx_word_s;
    logic                          lrck_n_r;
    logic [2:0]                    sync_r;
    logic                          start_s;
    state_t                        state_r;
    state_t                        state_s;
    logic [PTR_BITS-1:0]           idx_r;
    logic [PTR_BITS-1:0]           idx_s;
    logic signed [SAMPLE_SIZE-1:0] scaled_s;
    logic [PTR_BITS-1:0]           in_ptr_s;
    logic [PTR_BITS-1:0]           out_ptr_s;
    logic [SAMPLE_SIZE-1:0]        out_smp_s;
    logic                          pulse_s;

    // The incoming bit completes the word: with the I2S one-bit delay it is the
    // LSB of the slot that just ended.
    assign rx_word_s = {sh_rx_r[WORD_SIZE-2:0], din};
    assign tx_word_s = lrck_p_r ? r_din : l_din;

    // Receive shifter, word-select history and word capture on rising bck
    always_ff @(posedge bck) begin
        if (rst) begin
            sh_rx_r  <= {WORD_SIZE{1'b0}};
            lrck_p_r <= 1'b0;
            l_dout   <= {WORD_SIZE{1'b0}};
            r_dout   <= {WORD_SIZE{1'b0}};
        end else begin
            sh_rx_r  <= rx_word_s;
            lrck_p_r <= lrck;
            if (!lrck_p_r && lrck) begin
                l_dout <= rx_word_s;
            end else if (lrck_p_r && !lrck) begin
                r_dout <= rx_word_s;
            end
        end
    end

    // Transmit shifter on falling bck; loading a half-period after lrck_p moves
    // puts the MSB one full bck behind the lrck edge
    always_ff @(negedge bck) begin
        if (rst) begin
            lrck_n_r <= 1'b0;
            sh_tx_r  <= {WORD_SIZE{1'b0}};
            dout     <= 1'b0;
        end else begin
            lrck_n_r <= lrck_p_r;
            if (lrck_p_r != lrck_n_r) begin
                sh_tx_r <= tx_word_s;
                dout    <= tx_word_s[WORD_SIZE-1];
            end else begin
                sh_tx_r <= {sh_tx_r[WORD_SIZE-2:0], 1'b0};
                dout    <= sh_tx_r[WORD_SIZE-2];
            end
        end
    end

    // Two-flop synchroniser for chunk_pulse plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], chunk_pulse};
        end
    end

    assign start_s  = sync_r[1] & ~sync_r[2];
    assign scaled_s = $signed(input_buff_sample) >>> GAIN_SHIFT;

    // Processor state and sample index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {PTR_BITS{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state logic: three clk per sample, start ignored outside IDLE
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_ADDR;
                    idx_s   = {PTR_BITS{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_r == {PTR_BITS{1'b1}}) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ADDR;
                    idx_s   = idx_r + PTR_BITS'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {PTR_BITS{1'b0}};
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with ADDR (read address) and WRITE (write strobe) cycles
    always_comb begin
        in_ptr_s  = input_buff_ptr;
        out_ptr_s = output_buff_ptr;
        out_smp_s = output_buff_sample;
        pulse_s   = 1'b0;
        if (state_s == ST_ADDR) begin
            in_ptr_s = idx_s;
        end else begin
            in_ptr_s = input_buff_ptr;
        end
        if ((state_r == ST_WAIT) && (state_s == ST_WRITE)) begin
            out_ptr_s = idx_r;
            out_smp_s = scaled_s;
            pulse_s   = 1'b1;
        end else begin
            pulse_s   = 1'b0;
        end
    end

    // Registered buffer interface; pointers hold their last value while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            input_buff_ptr          <= {PTR_BITS{1'b0}};
            output_buff_ptr         <= {PTR_BITS{1'b0}};
            output_buff_sample      <= {SAMPLE_SIZE{1'b0}};
            output_buff_write_pulse <= 1'b0;
        end else begin
            input_buff_ptr          <= in_ptr_s;
            output_buff_ptr         <= out_ptr_s;
            output_buff_sample      <= out_smp_s;
            output_buff_write_pulse <= pulse_s;
        end
    end

endmodule

// File: tb/tb_i2s_stream_core.sv
// Self-checking bench for i2s_stream_core: I2S receive/loopback frames and chunk
// copies checked against a reference built from the stream format and buffer rules.
`timescale 1ns/100ps
module tb_i2s_stream_core;

    localparam int LOGN = 512;

    logic        clk = 1'b0;
    logic        bck = 1'b0;
    logic        rst = 1'b1;
    logic        lrck = 1'b0;
    logic        din_drv = 1'b0;
    logic        loop_en = 1'b0;
    logic        chunk_pulse = 1'b0;
    logic [31:0] l_din = 32'h0;
    logic [31:0] r_din = 32'h0;
    logic        din_s;

    wire [1:0][31:0] l_dout_w;
    wire [1:0][31:0] r_dout_w;
    wire [1:0]       dout_w;
    wire [1:0]       pulse_w;
    wire [1:0][5:0]  iptr_w;
    wire [1:0][5:0]  optr_w;
    wire [1:0][23:0] osmp_w;
    logic [23:0]     rdata0 = 24'h0;
    logic [23:0]     rdata1 = 24'h0;

    int mem0 [64];
    int mem1 [64];
    int exp0 [64];
    int exp1 [64];

    int          cyc = 0;
    int          tot [2] = '{0, 0};
    int          b2b [2] = '{0, 0};
    logic [1:0]  prev_p = 2'b00;
    logic [5:0]  log_ptr [2][LOGN];
    logic [23:0] log_smp [2][LOGN];
    int          log_cyc [2][LOGN];
    logic        dout_pos = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          rise_cyc = 0;
    logic        r_pend = 1'b0;
    logic [31:0] r_exp = 32'h0;
    logic        prev_lsb = 1'b0;

    assign din_s = loop_en ? dout_w[0] : din_drv;

    i2s_stream_core #(.GAIN_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .din(din_s),
        .l_dout(l_dout_w[0]), .r_dout(r_dout_w[0]), .l_din(l_din), .r_din(r_din),
        .dout(dout_w[0]), .chunk_pulse(chunk_pulse),
        .input_buff_ptr(iptr_w[0]), .input_buff_sample(rdata0),
        .output_buff_ptr(optr_w[0]), .output_buff_sample(osmp_w[0]),
        .output_buff_write_pulse(pulse_w[0])
    );

    i2s_stream_core #(.GAIN_SHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .din(din_drv),
        .l_dout(l_dout_w[1]), .r_dout(r_dout_w[1]), .l_din(l_din), .r_din(r_din),
        .dout(dout_w[1]), .chunk_pulse(chunk_pulse),
        .input_buff_ptr(iptr_w[1]), .input_buff_sample(rdata1),
        .output_buff_ptr(optr_w[1]), .output_buff_sample(osmp_w[1]),
        .output_buff_write_pulse(pulse_w[1])
    );

    // Clocks: bck edges offset by a fraction of a ns so they never meet a clk edge
    always #10 clk = ~clk;
    initial begin
        #0.3;
        forever #53 bck = ~bck;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM models, one clk of read latency
    always @(posedge clk) begin
        rdata0 <= 24'(mem0[iptr_w[0]]);
        rdata1 <= 24'(mem1[iptr_w[1]]);
    end

    always @(posedge bck) dout_pos <= dout_w[0];

    // Write logger for both processors
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pulse_w[d] === 1'b1) begin
                if (tot[d] < LOGN) begin
                    log_ptr[d][tot[d]] <= optr_w[d];
                    log_smp[d][tot[d]] <= osmp_w[d];
                    log_cyc[d][tot[d]] <= cyc;
                end
                tot[d] <= tot[d] + 1;
                if (prev_p[d]) b2b[d] <= b2b[d] + 1;
            end
            prev_p[d] <= pulse_w[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int floor_shift(input int v, input int s);
        int d;
        int q;
        d = 1 << s;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // One I2S frame of 32 bck per slot; lrck and din change on falling bck
    task automatic frame(input logic [31:0] lw, input logic [31:0] rw);
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 32; k++) begin
                @(negedge bck);
                if (s == 1 && k == 1) check("rx_left", l_dout_w[0], lw);
                if (s == 0 && k == 1 && r_pend) check("rx_right", r_dout_w[0], r_exp);
                if (k == 2 && loop_en) begin
                    if (s == 0) check("tx_msb_left", {31'b0, dout_pos}, {31'b0, lw[31]});
                    else        check("tx_msb_right", {31'b0, dout_pos}, {31'b0, rw[31]});
                end
                lrck = (s == 1);
                if (k == 0) din_drv = (s == 0) ? prev_lsb : lw[0];
                else        din_drv = (s == 0) ? lw[32-k] : rw[32-k];
            end
        end
        r_exp    = rw;
        r_pend   = 1'b1;
        prev_lsb = rw[0];
    endtask

    task automatic fill(input bit spec_pattern);
        logic signed [23:0] t;
        for (int i = 0; i < 64; i++) begin
            t = 24'($urandom);
            mem0[i] = spec_pattern ? (i * 1000 - 32000) : int'(t);
            t = 24'($urandom);
            mem1[i] = int'(t);
        end
        mem1[0] = -3;
        mem1[1] = 32'h007F_FFFF;
        for (int i = 0; i < 64; i++) begin
            exp0[i] = floor_shift(mem0[i], 0);
            exp1[i] = floor_shift(mem1[i], 1);
        end
    endtask

    task automatic pulse_chunk();
        @(negedge bck);
        chunk_pulse = 1'b1;
        rise_cyc = cyc;
        @(negedge bck);
        chunk_pulse = 1'b0;
    endtask

    task automatic wait_writes(input int d, input int target, input int budget);
        int n;
        n = 0;
        while (tot[d] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("write_timeout", {31'b0, tot[d] >= target}, 32'd1);
    endtask

    task automatic verify_chunk(input int b0, input int b1, input int r);
        int lat;
        check("count0", tot[0] - b0, 32'd64);
        check("count1", tot[1] - b1, 32'd64);
        check("no_b2b0", b2b[0], 32'd0);
        check("no_b2b1", b2b[1], 32'd0);
        for (int i = 0; i < 64; i++) begin
            check("ptr0", {26'b0, log_ptr[0][b0+i]}, i);
            check("smp0", {8'b0, log_smp[0][b0+i]}, {8'b0, 24'(exp0[i])});
            check("ptr1", {26'b0, log_ptr[1][b1+i]}, i);
            check("smp1", {8'b0, log_smp[1][b1+i]}, {8'b0, 24'(exp1[i])});
        end
        check("gain_neg3", {8'b0, log_smp[1][b1]}, {8'b0, 24'hFF_FFFE});
        check("gain_max", {8'b0, log_smp[1][b1+1]}, {8'b0, 24'h3F_FFFF});
        check("chunk_span", log_cyc[0][b0+63] - log_cyc[0][b0], 32'd189);
        lat = log_cyc[0][b0] - r;
        check("start_latency", {31'b0, (lat >= 5 && lat <= 6)}, 32'd1);
        check("iptr_hold", {26'b0, iptr_w[0]}, 32'd63);
        check("optr_hold", {26'b0, optr_w[0]}, 32'd63);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_l_dout", l_dout_w[d], 32'h0);
        check("rst_r_dout", r_dout_w[d], 32'h0);
        check("rst_dout", {31'b0, dout_w[d]}, 32'h0);
        check("rst_iptr", {26'b0, iptr_w[d]}, 32'h0);
        check("rst_optr", {26'b0, optr_w[d]}, 32'h0);
        check("rst_osmp", {8'b0, osmp_w[d]}, 32'h0);
        check("rst_pulse", {31'b0, pulse_w[d]}, 32'h0);
    endtask

    initial begin
        int b0;
        int b1;
        int r;

        // Power-on reset
        repeat (4) @(negedge bck);
        #2;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;

        // Receive: fixed words then random words
        frame(32'h1234_5600, 32'hABCD_EF00);
        frame(32'h1234_5600, 32'hABCD_EF00);
        for (int n = 0; n < 3; n++) frame($urandom, $urandom);

        // Transmit looped back into the receiver
        #1;
        r_pend  = 1'b0;
        loop_en = 1'b1;
        l_din   = 32'h8000_0100;
        r_din   = 32'h7FFF_FF00;
        frame(l_din, r_din);
        frame(l_din, r_din);
        for (int n = 0; n < 3; n++) begin
            #1;
            l_din = $urandom;
            r_din = $urandom;
            frame(l_din, r_din);
        end
        @(negedge bck);
        lrck    = 1'b0;
        loop_en = 1'b0;

        // Chunk with the ramp pattern (and gain checks on the shifted instance)
        fill(1'b1);
        b0 = tot[0];
        b1 = tot[1];
        pulse_chunk();
        r = rise_cyc;
        wait_writes(0, b0 + 64, 1000);
        repeat (300) @(posedge clk);
        verify_chunk(b0, b1, r);

        // Random data, second request arrives mid-chunk and must be ignored
        fill(1'b0);
        b0 = tot[0];
        b1 = tot[1];
        pulse_chunk();
        r = rise_cyc;
        wait_writes(0, b0 + 10, 400);
        pulse_chunk();
        wait_writes(0, b0 + 64, 1000);
        repeat (300) @(posedge clk);
        verify_chunk(b0, b1, r);

        // Reset in the middle of a chunk
        fill(1'b0);
        b0 = tot[0];
        b1 = tot[1];
        pulse_chunk();
        wait_writes(0, b0 + 30, 400);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge bck);
        #2;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("abort_count0", tot[0] - b0, 32'd30);
        check("abort_count1", tot[1] - b1, 32'd30);
        check("abort_iptr", {26'b0, iptr_w[0]}, 32'h0);
        check("abort_optr", {26'b0, optr_w[0]}, 32'h0);
        check("abort_osmp", {8'b0, osmp_w[0]}, 32'h0);
        check("abort_pulse", {31'b0, pulse_w[0]}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
